pe_feeder: RTL
==============

Name: pe_feeder

Overview:
- Sequencer on the driving side of a PE chain; the PE chain consumes mode, input, filter and activate signals, and this block produces them.
- Loads DEPTH weights in save mode, then streams len activations in systolic mode with a constant bias on pe_filter.
- Captures the chain's pe_out at a fixed latency and returns it on a result stream.
- Sits between the on-chip weight/activation buffers and the PE array.

Parameters:
DEPTH, 4, number of PEs in the chain = number of weight beats per job
LAT, 4, cycles from a PE-facing issue cycle to the matching valid value on pe_out_i (>=1)
CNT_W, 8, width of the len input and the sample counter

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
start  input  1  begin a job; honoured only in IDLE
len  input  CNT_W  number of activation samples for the job; latched on start
bias  input  8  value driven on pe_filter during systolic issue; latched on start
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse when a job fully completes
w_data  input  8  weight beat
w_valid  input  1  weight beat valid
w_ready  output  1  weight beat accepted when w_valid&&w_ready
x_data  input  8  activation sample
x_valid  input  1  activation sample valid
x_ready  output  1  activation sample accepted when x_valid&&x_ready
pe_in  output  8  to PE chain input
pe_filter  output  8  to PE chain filter/psum input
mode  output  2  to PE chain mode_i: 0 single, 1 systolic, 2 save weight, 3 initial/hold
activate  output  1  to PE chain activate
pe_sel  output  DEPTH  one-hot PE select for the current weight beat; zero otherwise
pe_out_i  input  8  from the last PE's pe_out
r_data  output  8  result sample
r_valid  output  1  result valid; no backpressure, sink must always accept

Behaviour:
- Clock and reset: single clock clk. Reset rst is synchronous and active-high.
- Values after reset:
  - state=IDLE, mode=3.
  - pe_in=0, pe_filter=0, activate=0, pe_sel=0.
  - w_ready=0, x_ready=0, r_valid=0, r_data=0, busy=0, done=0.
  - All counters and the result valid pipeline are cleared.
- Registered outputs: all PE-facing outputs are registered. A beat accepted in cycle t appears on the PE-facing outputs in cycle t+1 (the issue cycle).
- Ready signals: w_ready and x_ready are combinational from state and counters only; they never depend on w_valid or x_valid.
- IDLE:
  - mode=3; both readies low.
  - start=1 latches len and bias, clears counters and moves to LOAD next cycle.
  - A start in the same cycle as any valid does not accept that beat.
- LOAD:
  - w_ready=1 while the weight count wc<DEPTH.
  - Each accepted beat i (0..DEPTH-1) drives, in its issue cycle: mode=2, pe_filter=w_data, pe_sel=1<<i, pe_in=0, activate=0.
  - Cycles with no accept drive mode=3 and pe_sel=0 (PE holds).
  - After beat DEPTH-1 is accepted, go to RUN, or to DRAIN if len==0.
- RUN:
  - x_ready=1 while the sample count sc<len.
  - Each accept issues: mode=1, pe_in=x_data, pe_filter=bias, activate=1, and pushes a 1 into the valid pipeline.
  - A bubble (no accept) issues mode=3, activate=0 and pushes a 0.
  - When the last sample is accepted (sc reaches len), go to DRAIN.
- Valid pipeline:
  - A LAT-stage shift register advances every cycle in every non-IDLE state, including bubbles.
  - When its output bit is 1, pe_out_i is registered into r_data and r_valid=1 in the following cycle.
  - For issue cycle k, r_valid is high in cycle k+LAT+1.
- DRAIN:
  - mode=3; both readies low.
  - Stays until the valid pipeline is empty and the last r_valid has been emitted.
  - Then done=1 for one cycle, busy falls, and the state returns to IDLE.
- Counters:
  - wc counts 0..DEPTH. sc counts 0..len, width CNT_W.
  - len=2^CNT_W-1 is legal. No wrap-around occurs because comparison is against the latched len.
- Ignored events: start while busy is ignored. Changes to len or bias after start have no effect on the running job.
- Reset mid-operation: returns to IDLE within one cycle. In-flight results are discarded (no r_valid afterwards) and done is not pulsed.
- Busy timing: busy=1 from the cycle after an accepted start through the done cycle inclusive.

Test Plan:
- Weight load: DEPTH=4, back-to-back weights 0x11,0x22,0x33,0x44 -> four consecutive issue cycles with mode=2, pe_filter=0x11..0x44, pe_sel=0001,0010,0100,1000; then mode=1 region begins.
- Back-to-back stream: bias=0x05, len=3, x=0x01,0x02,0x03 back-to-back, pe_out_i modelled as registered pe_in+bias with LAT=4 -> activate high in 3 consecutive issue cycles; r_valid high 3 consecutive cycles at k+5 with r_data 0x06,0x07,0x08; done pulses once, then busy=0.
- Bubbles: len=2, x_valid gap of 2 cycles between samples -> two mode=3 cycles between the two issue cycles; r_valid pulses separated by 2 cycles; ordering preserved.
- len=0: weights load, then no x_ready assertion, no r_valid, done pulses and the block returns to IDLE.
- Ignored start: start pulsed during RUN with len=9 -> ignored; the job finishes with the original len of 3 results.
- Reset mid-job: rst asserted during RUN with 2 results in flight -> next cycle mode=3, activate=0, readies=0, busy=0; no r_valid and no done afterwards; a fresh job then completes normally.

Source files
------------

// File: rtl/pe_feeder.sv
// Feeds a PE chain: loads DEPTH weights in save mode, then streams activations in
// systolic mode with a fixed bias, and returns the chain output after LAT cycles.
module pe_feeder #(
  parameter int DEPTH = 4,
  parameter int LAT   = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  input  logic [7:0]       bias,
  output logic             busy,
  output logic             done,
  input  logic [7:0]       w_data,
  input  logic             w_valid,
  output logic             w_ready,
  input  logic [7:0]       x_data,
  input  logic             x_valid,
  output logic             x_ready,
  output logic [7:0]       pe_in,
  output logic [7:0]       pe_filter,
  output logic [1:0]       mode,
  output logic             activate,
  output logic [DEPTH-1:0] pe_sel,
  input  logic [7:0]       pe_out_i,
  output logic [7:0]       r_data,
  output logic             r_valid
);

  localparam int WC_W = $clog2(DEPTH + 1);
  localparam logic [WC_W-1:0] WC_FULL = WC_W'(DEPTH);

  localparam logic [1:0] MODE_SYST = 2'd1;
  localparam logic [1:0] MODE_SAVE = 2'd2;
  localparam logic [1:0] MODE_HOLD = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    RUN   = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t           state_r;
  logic [CNT_W-1:0] len_r;
  logic [CNT_W-1:0] sc_r;
  logic [7:0]       bias_r;
  logic [WC_W-1:0]  wc_r;
  logic [LAT-1:0]   vpipe_r;

  logic [1:0]       mode_r;
  logic [7:0]       pe_in_r;
  logic [7:0]       pe_filter_r;
  logic             activate_r;
  logic [DEPTH-1:0] pe_sel_r;
  logic             busy_r;
  logic             done_r;
  logic [7:0]       r_data_r;
  logic             r_valid_r;

  logic             w_ready_s;
  logic             x_ready_s;
  logic             w_acc_s;
  logic             x_acc_s;
  logic             drained_s;
  logic [CNT_W-1:0] sc_inc_s;
  logic [WC_W-1:0]  wc_inc_s;

  function automatic logic [DEPTH-1:0] onehot(input logic [WC_W-1:0] idx);
    logic [DEPTH-1:0] res;
    res = {DEPTH{1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      res[i] = (idx == WC_W'(i));
    end
    return res;
  endfunction

  // Readies depend only on state and counters, never on the valids.
  always_comb begin
    w_ready_s = 1'b0;
    x_ready_s = 1'b0;
    case (state_r)
      LOAD: begin
        w_ready_s = (wc_r < WC_FULL);
        x_ready_s = 1'b0;
      end
      RUN: begin
        w_ready_s = 1'b0;
        x_ready_s = (sc_r < len_r);
      end
      default: begin
        w_ready_s = 1'b0;
        x_ready_s = 1'b0;
      end
    endcase
  end

  assign w_acc_s   = w_valid && w_ready_s;
  assign x_acc_s   = x_valid && x_ready_s;
  assign sc_inc_s  = sc_r + CNT_W'(1);
  assign wc_inc_s  = wc_r + WC_W'(1);
  // Nothing issued this cycle and nothing in flight: the last result is already out.
  assign drained_s = !activate_r && (vpipe_r == {LAT{1'b0}});

  // Job sequencer and registered PE-facing outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      len_r       <= {CNT_W{1'b0}};
      bias_r      <= 8'd0;
      wc_r        <= {WC_W{1'b0}};
      sc_r        <= {CNT_W{1'b0}};
      mode_r      <= MODE_HOLD;
      pe_in_r     <= 8'd0;
      pe_filter_r <= 8'd0;
      activate_r  <= 1'b0;
      pe_sel_r    <= {DEPTH{1'b0}};
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      mode_r      <= MODE_HOLD;
      pe_in_r     <= 8'd0;
      pe_filter_r <= 8'd0;
      activate_r  <= 1'b0;
      pe_sel_r    <= {DEPTH{1'b0}};
      done_r      <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            len_r   <= len;
            bias_r  <= bias;
            wc_r    <= {WC_W{1'b0}};
            sc_r    <= {CNT_W{1'b0}};
            busy_r  <= 1'b1;
            state_r <= LOAD;
          end else begin
            busy_r  <= 1'b0;
          end
        end
        LOAD: begin
          busy_r <= 1'b1;
          if (w_acc_s) begin
            mode_r      <= MODE_SAVE;
            pe_filter_r <= w_data;
            pe_sel_r    <= onehot(wc_r);
            wc_r        <= wc_inc_s;
            if (wc_inc_s == WC_FULL) begin
              state_r <= (len_r == {CNT_W{1'b0}}) ? DRAIN : RUN;
            end
          end
        end
        RUN: begin
          busy_r <= 1'b1;
          if (x_acc_s) begin
            mode_r      <= MODE_SYST;
            pe_in_r     <= x_data;
            pe_filter_r <= bias_r;
            activate_r  <= 1'b1;
            sc_r        <= sc_inc_s;
            if (sc_inc_s == len_r) begin
              state_r <= DRAIN;
            end
          end
        end
        DRAIN: begin
          // done is raised while still in DRAIN so busy covers the done cycle.
          if (done_r) begin
            busy_r  <= 1'b0;
            state_r <= IDLE;
          end else begin
            busy_r  <= 1'b1;
            done_r  <= drained_s;
          end
        end
        default: begin
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  // Valid pipeline tracks each issue cycle to the cycle pe_out_i carries its result.
  always_ff @(posedge clk) begin
    if (rst) begin
      vpipe_r   <= {LAT{1'b0}};
      r_valid_r <= 1'b0;
      r_data_r  <= 8'd0;
    end else if (state_r == IDLE) begin
      vpipe_r   <= {LAT{1'b0}};
      r_valid_r <= 1'b0;
    end else begin
      vpipe_r[0] <= activate_r;
      for (int i = 1; i < LAT; i++) begin
        vpipe_r[i] <= vpipe_r[i-1];
      end
      r_valid_r <= vpipe_r[LAT-1];
      if (vpipe_r[LAT-1]) begin
        r_data_r <= pe_out_i;
      end
    end
  end

  assign w_ready   = w_ready_s;
  assign x_ready   = x_ready_s;
  assign mode      = mode_r;
  assign pe_in     = pe_in_r;
  assign pe_filter = pe_filter_r;
  assign activate  = activate_r;
  assign pe_sel    = pe_sel_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign r_data    = r_data_r;
  assign r_valid   = r_valid_r;

endmodule
